aux_io_mailbox: RTL

Multi-channel, single-clock successor to the CalPC/host auxiliary I/O block. It provides N_CH independent bidirectional mailboxes. Each mailbox has a TX FIFO (control to host) and an RX FIFO (host to control). The control side keeps the familiar request/busy register interface. The host side is a flattened per-channel streaming port with block-threshold ready flags. New behaviour: channel select, configurable read timeout, per-channel status word and sticky overflow/underflow flags.

---
 rtl/aux_io_pkg.sv | 10 +
 rtl/sync_fifo_usedw.sv | 47 ++++
 rtl/aux_io_mailbox.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/aux_io_pkg.sv
// aux_io_pkg: shared FSM encoding and status-word layout for the aux I/O mailbox
package aux_io_pkg;
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DATA, WR_WAIT} state_e;
  localparam int RX_USED_LSB = 0;
  localparam int TX_USED_LSB = 16;
  localparam int OVF_BIT = 30;
  localparam int UDF_BIT = 31;
  localparam int CH_SEL_W = 4;
  localparam int STATUS_SEL_BIT = 16;
endpackage

// File: rtl/sync_fifo_usedw.sv
// sync_fifo_usedw: single-clock FIFO with registered q and a full-range used-word count
module sync_fifo_usedw #(
  parameter int W = 32,
  parameter int AW = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  usedw_o
);
  localparam int UW = AW + 1;
  logic [W-1:0] mem [2**AW];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] used_q, used_d;
  logic [W-1:0] q_q;
  logic do_push, do_pop;
  assign empty_o = used_q == '0;
  assign full_o = used_q[AW];
  assign usedw_o = used_q;
  assign q_o = q_q;
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i);
  assign used_d = used_q + UW'(do_push) - UW'(do_pop);
  // pointers, count and output word; reset edge performs no push or pop
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q <= '0;
      rp_q <= '0;
      used_q <= '0;
      q_q <= '0;
    end else begin
      wp_q <= do_push ? wp_q + AW'(1) : wp_q;
      rp_q <= do_pop ? rp_q + AW'(1) : rp_q;
      used_q <= used_d;
      q_q <= do_pop ? mem[rp_q] : q_q;
    end
  end
  // storage array, left unreset so it can map onto block RAM
  always_ff @(posedge clk) begin
    if (reset && do_push) mem[wp_q] <= d_i;
  end
endmodule

// File: rtl/aux_io_mailbox.sv
// aux_io_mailbox: multi-channel control/host mailbox with request/busy control port and streaming host port
module aux_io_mailbox
  import aux_io_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_CH = 2,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_BLOCK = 4,
  parameter int WR_BLOCK = 512,
  parameter int TIMEOUT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   write_req,
  input  logic                   read_req,
  input  logic [16:0]            address,
  input  logic [DATA_W-1:0]      data_write,
  output logic [DATA_W-1:0]      data_read,
  output logic                   busy,
  output logic                   err,
  input  logic [TIMEOUT_W-1:0]   timeout,
  input  logic [N_CH-1:0]        host_rd,
  output logic [N_CH*DATA_W-1:0] host_rd_data,
  output logic [N_CH-1:0]        host_rd_ready,
  input  logic [N_CH-1:0]        host_wr,
  input  logic [N_CH*DATA_W-1:0] host_wr_data,
  output logic [N_CH-1:0]        host_wr_ready
);
  localparam int UW = DEPTH_LOG2 + 1;
  localparam logic [UW-1:0] RD_TH = UW'(RD_BLOCK);
  localparam logic [UW-1:0] WR_TH = UW'(WR_BLOCK);
  localparam logic [UW-1:0] DEPTH = UW'(1 << DEPTH_LOG2);
  state_e state_q, state_d;
  logic [CH_SEL_W-1:0] ch_q, ch_d;
  logic sts_q, sts_d, busy_q, busy_d, err_q, err_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, data_read_q, data_read_d;
  logic [TIMEOUT_W-1:0] tmr_q, tmr_d;
  logic [N_CH-1:0] ovf_q, ovf_d, udf_q, udf_d;
  logic rx_pop, tx_push, sticky_clr, bad_ch, tmo;
  logic [N_CH-1:0] rx_empty, rx_full, tx_empty, tx_full, rx_pop_v, tx_push_v, ch_oh, rx_drop, tx_miss;
  logic [UW-1:0] rx_used [N_CH];
  logic [UW-1:0] tx_used [N_CH];
  logic [DATA_W-1:0] rx_q [N_CH];
  logic rx_empty_s, tx_full_s, ovf_s, udf_s;
  logic [UW-1:0] rx_used_s, tx_used_s;
  logic [DATA_W-1:0] rx_q_s, status_word;
  assign bad_ch = int'(address[CH_SEL_W-1:0]) >= N_CH;
  assign tmo = timeout != '0 && tmr_q >= timeout;
  assign busy = busy_q;
  assign err = err_q;
  assign data_read = data_read_q;
  assign rx_pop_v = rx_pop ? ch_oh : '0;
  assign tx_push_v = tx_push ? ch_oh : '0;
  // a host push into a full RX FIFO is dropped unless the control side pops it the same cycle
  assign rx_drop = host_wr & rx_full & ~rx_pop_v;
  assign tx_miss = host_rd & tx_empty;
  assign ovf_d = (ovf_q & ~(sticky_clr ? ch_oh : '0)) | rx_drop;
  assign udf_d = (udf_q & ~(sticky_clr ? ch_oh : '0)) | tx_miss;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    sync_fifo_usedw #(.W(DATA_W), .AW(DEPTH_LOG2)) u_tx (
      .clk     (clk),
      .reset   (reset),
      .push_i  (tx_push_v[c]),
      .pop_i   (host_rd[c]),
      .d_i     (wdata_q),
      .q_o     (host_rd_data[c*DATA_W +: DATA_W]),
      .full_o  (tx_full[c]),
      .empty_o (tx_empty[c]),
      .usedw_o (tx_used[c])
    );
    sync_fifo_usedw #(.W(DATA_W), .AW(DEPTH_LOG2)) u_rx (
      .clk     (clk),
      .reset   (reset),
      .push_i  (host_wr[c]),
      .pop_i   (rx_pop_v[c]),
      .d_i     (host_wr_data[c*DATA_W +: DATA_W]),
      .q_o     (rx_q[c]),
      .full_o  (rx_full[c]),
      .empty_o (rx_empty[c]),
      .usedw_o (rx_used[c])
    );
    assign host_rd_ready[c] = tx_used[c] >= RD_TH;
    assign host_wr_ready[c] = DEPTH - rx_used[c] >= WR_TH;
  end
  // route the latched channel's FIFO state and sticky flags to the control side
  always_comb begin
    ch_oh = '0;
    rx_empty_s = 1'b1;
    tx_full_s = 1'b0;
    rx_used_s = '0;
    tx_used_s = '0;
    rx_q_s = '0;
    ovf_s = 1'b0;
    udf_s = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_q == CH_SEL_W'(i)) begin
        ch_oh[i] = 1'b1;
        rx_empty_s = rx_empty[i];
        tx_full_s = tx_full[i];
        rx_used_s = rx_used[i];
        tx_used_s = tx_used[i];
        rx_q_s = rx_q[i];
        ovf_s = ovf_q[i];
        udf_s = udf_q[i];
      end
    end
  end
  // assemble the per-channel status word
  always_comb begin
    status_word = '0;
    status_word[RX_USED_LSB +: UW] = rx_used_s;
    status_word[TX_USED_LSB +: UW] = tx_used_s;
    status_word[OVF_BIT] = ovf_s;
    status_word[UDF_BIT] = udf_s;
  end
  // control FSM state register
  always_ff @(posedge clk) begin
    state_q <= !reset ? IDLE : state_d;
  end
  // control FSM next state; read wins over write, bad channels never leave IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (!read_req && !write_req) || bad_ch ? IDLE :
                         read_req ? (address[STATUS_SEL_BIT] ? RD_DATA : RD_WAIT) : WR_WAIT;
      RD_WAIT: state_d = !rx_empty_s ? RD_DATA : tmo ? IDLE : RD_WAIT;
      RD_DATA: state_d = IDLE;
      WR_WAIT: state_d = tx_full_s ? WR_WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // control FSM outputs: FIFO strobes and next values of the control registers
  always_comb begin
    ch_d = ch_q;
    sts_d = sts_q;
    wdata_d = wdata_q;
    data_read_d = data_read_q;
    busy_d = busy_q;
    err_d = err_q;
    tmr_d = tmr_q;
    rx_pop = 1'b0;
    tx_push = 1'b0;
    sticky_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_req || write_req) begin
          err_d = bad_ch;
          busy_d = !bad_ch;
          ch_d = address[CH_SEL_W-1:0];
          sts_d = read_req && address[STATUS_SEL_BIT];
          wdata_d = data_write;
          tmr_d = '0;
        end
      end
      RD_WAIT: begin
        tmr_d = tmr_q + TIMEOUT_W'(1);
        rx_pop = !rx_empty_s;
        err_d = rx_empty_s && tmo ? 1'b1 : err_q;
        busy_d = !(rx_empty_s && tmo);
      end
      RD_DATA: begin
        data_read_d = sts_q ? status_word : rx_q_s;
        busy_d = 1'b0;
        sticky_clr = sts_q;
      end
      WR_WAIT: begin
        tx_push = !tx_full_s;
        busy_d = tx_full_s;
      end
      default: ;
    endcase
  end
  // control registers and sticky flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      ch_q <= '0;
      sts_q <= 1'b0;
      wdata_q <= '0;
      data_read_q <= '0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
      tmr_q <= '0;
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      ch_q <= ch_d;
      sts_q <= sts_d;
      wdata_q <= wdata_d;
      data_read_q <= data_read_d;
      busy_q <= busy_d;
      err_q <= err_d;
      tmr_q <= tmr_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
endmodule
